// File: rtl/tdc_interval_builder.sv
// Start/stop TDC interval builder: timestamps hits on a free-running coarse
// counter, reads both fine codes over a shared encoder bus, and emits the
// start-to-stop interval in fine-bin units through a valid/ready handshake.
module tdc_interval_builder #(
  parameter int unsigned COARSE_W    = 16,
  parameter int unsigned FINE_BINS   = 40,
  parameter int unsigned RES_W       = 22,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_det,
  input  logic             stop_det,
  input  logic [7:0]       fine_bus,
  output logic             sel_start_n,
  output logic             sel_stop_n,
  output logic [RES_W-1:0] meas,
  output logic [1:0]       meas_err,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             busy,
  output logic [7:0]       missed_cnt
);

  localparam int unsigned CALC_W = RES_W + 1;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CODE    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_NEG     = 2'd3;

  typedef enum logic [2:0] {
    IDLE, SEL_S, SMP_S, WAIT_STOP, SEL_P, SMP_P, CALC, OUT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [COARSE_W-1:0] r_coarse;
  logic [COARSE_W-1:0] r_cs, r_cp, w_cs_nxt, w_cp_nxt;
  logic                r_pend, w_pend_nxt;
  logic [7:0]          r_fs, r_fp, w_fs_nxt, w_fp_nxt;
  logic [RES_W-1:0]    r_meas, w_meas_nxt;
  logic [1:0]          r_err, w_err_nxt;
  logic                r_valid, r_busy, r_sel_start_n, r_sel_stop_n;
  logic [7:0]          r_missed;

  logic [COARSE_W-1:0] w_elapsed;
  logic [COARSE_W-1:0] w_dcoarse;
  logic [CALC_W-1:0]   w_t;
  logic                w_codes_ok;

  assign w_elapsed = r_coarse - r_cs;
  assign w_dcoarse = r_cp - r_cs;
  // Written as a positive "in range" test so an unknown code falls into the error branch.
  assign w_codes_ok = (r_fs != 8'd0) && (r_fs <= 8'(FINE_BINS)) &&
                      (r_fp != 8'd0) && (r_fp <= 8'(FINE_BINS));
  // Interval in fine bins; the MSB is the sign (the positive range never reaches it).
  assign w_t = CALC_W'(w_dcoarse) * CALC_W'(FINE_BINS) + CALC_W'(r_fs) - CALC_W'(r_fp);

  // Free-running coarse timestamp counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_coarse <= '0;
    else        r_coarse <= r_coarse + COARSE_W'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, timestamp capture and result computation.
  always_comb begin
    w_state_nxt = r_state;
    w_cs_nxt    = r_cs;
    w_cp_nxt    = r_cp;
    w_pend_nxt  = r_pend;
    w_fs_nxt    = r_fs;
    w_fp_nxt    = r_fp;
    w_meas_nxt  = r_meas;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (start_det) begin
          w_state_nxt = SEL_S;
          w_cs_nxt    = r_coarse;
          w_pend_nxt  = stop_det;
          if (stop_det) w_cp_nxt = r_coarse;
        end
      end
      SEL_S: begin
        w_state_nxt = SMP_S;
        if (stop_det && !r_pend) begin
          w_pend_nxt = 1'b1;
          w_cp_nxt   = r_coarse;
        end
      end
      SMP_S: begin
        w_fs_nxt = fine_bus;
        if (stop_det && !r_pend) begin
          w_pend_nxt = 1'b1;
          w_cp_nxt   = r_coarse;
        end
        w_state_nxt = (r_pend || stop_det) ? SEL_P : WAIT_STOP;
      end
      WAIT_STOP: begin
        if (stop_det) begin
          w_cp_nxt    = r_coarse;
          w_state_nxt = SEL_P;
        end else if (w_elapsed == COARSE_W'(TIMEOUT_CYC)) begin
          w_meas_nxt  = '1;
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = OUT;
        end
      end
      SEL_P: w_state_nxt = SMP_P;
      SMP_P: begin
        w_fp_nxt    = fine_bus;
        w_state_nxt = CALC;
      end
      CALC: begin
        w_state_nxt = OUT;
        if (w_codes_ok) begin
          if (w_t[RES_W]) begin
            w_meas_nxt = '0;
            w_err_nxt  = ERR_NEG;
          end else begin
            w_meas_nxt = w_t[RES_W-1:0];
            w_err_nxt  = ERR_OK;
          end
        end else begin
          w_meas_nxt = '0;
          w_err_nxt  = ERR_CODE;
        end
      end
      OUT: begin
        if (meas_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers; status outputs are decoded from the next state so they track the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs          <= '0;
      r_cp          <= '0;
      r_pend        <= 1'b0;
      r_fs          <= '0;
      r_fp          <= '0;
      r_meas        <= '0;
      r_err         <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_sel_start_n <= 1'b1;
      r_sel_stop_n  <= 1'b1;
    end else begin
      r_cs          <= w_cs_nxt;
      r_cp          <= w_cp_nxt;
      r_pend        <= w_pend_nxt;
      r_fs          <= w_fs_nxt;
      r_fp          <= w_fp_nxt;
      r_meas        <= w_meas_nxt;
      r_err         <= w_err_nxt;
      r_valid       <= (w_state_nxt == OUT);
      r_busy        <= (w_state_nxt != IDLE);
      r_sel_start_n <= !((w_state_nxt == SEL_S) || (w_state_nxt == SMP_S));
      r_sel_stop_n  <= !((w_state_nxt == SEL_P) || (w_state_nxt == SMP_P));
    end
  end

  // Saturating count of starts that arrive while a measurement is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                   r_missed <= '0;
    else if (start_det && (r_state != IDLE) && (r_missed != 8'hFF)) r_missed <= r_missed + 8'd1;
  end

  assign sel_start_n = r_sel_start_n;
  assign sel_stop_n  = r_sel_stop_n;
  assign meas        = r_meas;
  assign meas_err    = r_err;
  assign meas_valid  = r_valid;
  assign busy        = r_busy;
  assign missed_cnt  = r_missed;

endmodule

// File: tb/tb_tdc_interval_builder.sv
// Randomized self-checking bench for tdc_interval_builder with a
// transaction-level interval model and an encoder model on the fine bus.
module tb_tdc_interval_builder;

  localparam int FINE_BINS   = 40;
  localparam int TIMEOUT_CYC = 1000;
  localparam int WAIT_MAX    = 70000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_det = 1'b0;
  logic        stop_det = 1'b0;
  logic [7:0]  fine_bus;
  logic        sel_start_n, sel_stop_n;
  logic [21:0] meas;
  logic [1:0]  meas_err;
  logic        meas_valid;
  logic        meas_ready = 1'b0;
  logic        busy;
  logic [7:0]  missed_cnt;

  logic [7:0]  start_code = 8'd0;
  logic [7:0]  stop_code = 8'd0;
  logic [15:0] tb_coarse;
  int          n_chk = 0;
  int          n_fail = 0;
  int          missed_model = 0;

  tdc_interval_builder dut (
    .clk(clk), .rst_n(rst_n), .start_det(start_det), .stop_det(stop_det),
    .fine_bus(fine_bus), .sel_start_n(sel_start_n), .sel_stop_n(sel_stop_n),
    .meas(meas), .meas_err(meas_err), .meas_valid(meas_valid),
    .meas_ready(meas_ready), .busy(busy), .missed_cnt(missed_cnt)
  );

  always #5 clk = ~clk;

  // Encoder model: whichever encoder is enabled drives the bus, otherwise junk.
  assign fine_bus = (!sel_start_n) ? start_code : (!sel_stop_n) ? stop_code : 8'hEE;

  // Bench copy of the coarse time base (cycles since reset, modulo 2^16).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_coarse <= 16'd0;
    else        tb_coarse <= tb_coarse + 16'd1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One measurement: start (optionally at a given coarse value), stop k cycles later
  // (k<0 = never), then hold off the consumer for 'hold' cycles with 'pulses' extra starts.
  task automatic run_meas(input int start_at, input int k, input logic [7:0] sc,
                          input logic [7:0] pc, input int hold, input int pulses,
                          input bit hs_pulse);
    int          waited, i, exp_cyc, t, d;
    logic [15:0] cs, cp;
    logic [21:0] exp_m, m0;
    logic [1:0]  exp_e, e0;
    bit          seen, overlap, stable;
    waited = 0;
    cp = 16'd0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while ((busy || ((start_at >= 0) && (tb_coarse != 16'(start_at)))) && (waited < WAIT_MAX));
    if (waited >= WAIT_MAX) begin
      check("start_wait", 1, 0);
      return;
    end
    start_code = sc;
    stop_code  = pc;
    start_det  = 1'b1;
    cs = tb_coarse;
    if (k == 0) begin
      stop_det = 1'b1;
      cp = tb_coarse;
    end
    exp_cyc = (k < 0) ? TIMEOUT_CYC + 1 : ((k < 2) ? 2 : k) + 4;
    i = 0; seen = 0; overlap = 0;
    while (!seen && (i < exp_cyc + 10)) begin
      @(negedge clk);
      if (!sel_start_n && !sel_stop_n) overlap = 1;
      if (meas_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        i++;
        start_det = 1'b0;
        stop_det  = (i == k);
        if (i == k) cp = tb_coarse;
      end
    end
    start_det = 1'b0;
    stop_det  = 1'b0;
    if (k < 0) begin
      exp_m = 22'h3FFFFF; exp_e = 2'd2;
    end else if (sc == 8'd0 || sc > 8'(FINE_BINS) || pc == 8'd0 || pc > 8'(FINE_BINS)) begin
      exp_m = 22'd0; exp_e = 2'd1;
    end else begin
      t = int'(16'(cp - cs)) * FINE_BINS + int'(sc) - int'(pc);
      if (t < 0) begin exp_m = 22'd0; exp_e = 2'd3; end
      else       begin exp_m = 22'(t); exp_e = 2'd0; end
    end
    check("valid_latency", i, exp_cyc);
    check("meas", longint'(meas), longint'(exp_m));
    check("meas_err", longint'(meas_err), longint'(exp_e));
    check("sel_overlap", overlap, 0);
    m0 = meas; e0 = meas_err; stable = 1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      start_det = ((h % 5) == 0) && ((h / 5) < pulses);
      if (start_det && missed_model < 255) missed_model++;
      @(negedge clk);
      if (meas !== m0 || meas_err !== e0 || meas_valid !== 1'b1) stable = 0;
    end
    @(posedge clk); #1;
    start_det  = hs_pulse;
    if (hs_pulse && missed_model < 255) missed_model++;
    meas_ready = 1'b1;
    @(posedge clk); #1;
    start_det  = 1'b0;
    meas_ready = 1'b0;
    check("hold_stable", stable, 1);
    check("valid_after_hs", longint'(meas_valid), 0);
    check("busy_after_hs", longint'(busy), 0);
    check("missed_cnt", longint'(missed_cnt), longint'(missed_model));
  endtask

  function automatic logic [7:0] rnd_code();
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(1, FINE_BINS));
  endfunction

  task automatic check_reset_vals();
    check("rst_sel_start_n", longint'(sel_start_n), 1);
    check("rst_sel_stop_n", longint'(sel_stop_n), 1);
    check("rst_meas", longint'(meas), 0);
    check("rst_meas_err", longint'(meas_err), 0);
    check("rst_meas_valid", longint'(meas_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_missed_cnt", longint'(missed_cnt), 0);
  endtask

  initial begin
    int hold;
    repeat (3) @(negedge clk);
    check_reset_vals();
    #2 rst_n = 1'b1;

    // Basic interval at coarse 10 -> 13.
    run_meas(10, 3, 8'd25, 8'd7, 0, 0, 0);
    // Stop in the same cycle as the start; positive and negative result.
    run_meas(-1, 0, 8'd30, 8'd12, 0, 0, 0);
    run_meas(-1, 0, 8'd5, 8'd20, 0, 0, 0);
    // Stop arriving during start-code readout.
    run_meas(-1, 1, 8'd8, 8'd33, 0, 0, 0);
    run_meas(-1, 2, 8'd40, 8'd1, 0, 0, 0);
    // Invalid fine codes.
    run_meas(-1, 4, 8'd0, 8'd10, 0, 0, 0);
    run_meas(-1, 4, 8'd41, 8'd10, 0, 0, 0);
    run_meas(-1, 4, 8'd10, 8'd0, 0, 0, 0);
    run_meas(-1, 4, 8'd10, 8'd41, 0, 0, 0);
    // Timeout, and a stop exactly on the timeout cycle.
    run_meas(-1, -1, 8'd10, 8'd10, 0, 0, 0);
    run_meas(-1, TIMEOUT_CYC, 8'd15, 8'd3, 0, 0, 0);
    // Backpressure with three ignored starts, then one on the handshake cycle.
    run_meas(-1, 5, 8'd20, 8'd20, 20, 3, 0);
    run_meas(-1, 6, 8'd21, 8'd19, 2, 0, 1);

    for (int n = 0; n < 40; n++) begin
      hold = $urandom_range(0, 6);
      run_meas(-1, $urandom_range(0, 12), rnd_code(), rnd_code(), hold,
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Coarse wrap: 65534 -> 2.
    run_meas(65534, 4, 8'd10, 8'd10, 0, 0, 0);

    // Reset asserted while the stop encoder is selected.
    begin
      int waited = 0;
      do begin @(posedge clk); #1; waited++; end while (busy && waited < 100);
      start_code = 8'd12; stop_code = 8'd9;
      start_det = 1'b1;
      @(posedge clk); #1; start_det = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; stop_det = 1'b1;
      @(posedge clk); #1; stop_det = 1'b0;
      check("selp_before_rst", longint'(sel_stop_n), 0);
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      missed_model = 0;
      @(negedge clk); #2 rst_n = 1'b1;
    end
    run_meas(-1, 3, 8'd20, 8'd10, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
